// File: rtl/scan_loader.sv
// Serial scan-chain loader: shifts bytes MSB-first into a selected buffer chain
// while capturing the chain's returned bits, two clk cycles per serial bit.
module scan_loader #(
    parameter int buffer_size  = 12,
    parameter int buffer_width = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [2:0]              addr,
    input  logic                    abort,
    input  logic [buffer_width-1:0] in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic                    sclk,
    output logic                    sin,
    input  logic                    sout,
    output logic                    ssel,
    output logic [2:0]              saddr,
    output logic [buffer_width-1:0] rd_data,
    output logic                    rd_valid,
    output logic                    busy,
    output logic                    done
);
    localparam int BYW = (buffer_size > 1) ? $clog2(buffer_size) : 1;
    localparam int BTW = (buffer_width > 1) ? $clog2(buffer_width) : 1;
    localparam logic [BYW-1:0] BYTE_LAST = BYW'(buffer_size - 1);
    localparam logic [BTW-1:0] BIT_LAST  = BTW'(buffer_width - 1);

    typedef enum logic [2:0] {
        IDLE, SETUP, WAIT_BYTE, SHIFT_LO, SHIFT_HI, FINISH
    } state_t;

    state_t                  state;
    logic [BYW-1:0]          byte_cnt;
    logic [BTW-1:0]          bit_cnt;
    // Only the bits still to be sent; the MSB in flight lives in sin.
    logic [buffer_width-2:0] shreg;
    logic [buffer_width-1:0] rback;

    assign in_ready = (state == WAIT_BYTE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            byte_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            rback    <= '0;
            sclk     <= 1'b0;
            sin      <= 1'b0;
            ssel     <= 1'b0;
            saddr    <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            done     <= 1'b0;
            if (abort) begin
                // sclk and ssel drop together, so ssel never moves while sclk is high.
                state    <= IDLE;
                sclk     <= 1'b0;
                sin      <= 1'b0;
                ssel     <= 1'b0;
                busy     <= 1'b0;
                byte_cnt <= '0;
                bit_cnt  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state    <= SETUP;
                            saddr    <= addr;
                            ssel     <= 1'b1;
                            sclk     <= 1'b0;
                            busy     <= 1'b1;
                        end
                    end
                    SETUP: begin
                        byte_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= WAIT_BYTE;
                    end
                    WAIT_BYTE: begin
                        if (in_valid) begin
                            sin     <= in_data[buffer_width-1];
                            shreg   <= in_data[buffer_width-2:0];
                            bit_cnt <= '0;
                            state   <= SHIFT_LO;
                        end
                    end
                    SHIFT_LO: begin
                        rback <= {rback[buffer_width-2:0], sout};
                        sclk  <= 1'b1;
                        state <= SHIFT_HI;
                    end
                    SHIFT_HI: begin
                        sclk <= 1'b0;
                        if (bit_cnt != BIT_LAST) begin
                            bit_cnt <= bit_cnt + 1'b1;
                            sin     <= shreg[buffer_width-2];
                            shreg   <= shreg << 1;
                            state   <= SHIFT_LO;
                        end else begin
                            rd_data  <= rback;
                            rd_valid <= 1'b1;
                            bit_cnt  <= '0;
                            if (byte_cnt != BYTE_LAST) begin
                                byte_cnt <= byte_cnt + 1'b1;
                                state    <= WAIT_BYTE;
                            end else begin
                                ssel  <= 1'b0;
                                sin   <= 1'b0;
                                done  <= 1'b1;
                                state <= FINISH;
                            end
                        end
                    end
                    FINISH: begin
                        busy     <= 1'b0;
                        byte_cnt <= '0;
                        state    <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_scan_loader.sv
// Directed bench for scan_loader with a serial chain model and a readback scoreboard.
module tb_scan_loader;
    localparam int NB = 12;
    localparam int W  = 8;
    localparam int NBITS = NB * W;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, in_valid = 1'b0;
    logic [2:0] addr = '0;
    logic [W-1:0] in_data = '0;
    logic in_ready, sclk, sin, sout, ssel, rd_valid, busy, done;
    logic [2:0] saddr;
    logic [W-1:0] rd_data;

    always #5 clk = ~clk;

    scan_loader #(.buffer_size(NB), .buffer_width(W)) dut (
        .clk(clk), .rst(rst), .start(start), .addr(addr), .abort(abort),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .sclk(sclk), .sin(sin), .sout(sout), .ssel(ssel), .saddr(saddr),
        .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done)
    );

    // Chain model: one long shift register, old MSB returned on sout.
    logic [NBITS-1:0] chain, load_val;
    logic load = 1'b0;
    assign sout = chain[NBITS-1];
    always @(posedge sclk or posedge load)
        if (load) chain <= load_val;
        else if (ssel) chain <= {chain[NBITS-2:0], sin};

    int passed = 0, total = 0;
    logic [W-1:0] exp_q[$], got_q[$];
    logic [W-1:0] tx[NB];

    int done_cyc, ndone, npulse, pause_cnt, idx;
    logic saddr_bad, ssel1, pause_bad, aborting, prev_sclk;
    logic [2:0] post_abort;
    logic [17:0] rst_vals;
    logic [W-1:0] sin_cap;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    endtask

    function automatic logic [NBITS-1:0] pack_tx();
        logic [NBITS-1:0] p = '0;
        for (int n = 0; n < NB; n++) p[NBITS-1-W*n -: W] = tx[n];
        return p;
    endfunction

    task automatic preload(input logic [NBITS-1:0] v);
        load_val = v; load = 1'b1; #1; load = 1'b0;
    endtask

    task automatic xfer(input logic [2:0] a, input int pause_at, input int abort_byte,
                        input int rst_byte, input int bstart_cyc);
        int cyc;
        logic want;
        for (int n = 0; n < NB; n++) exp_q.push_back(chain[NBITS-1-W*n -: W]);
        done_cyc = -1; ndone = 0; npulse = 0; pause_cnt = 0; idx = 0;
        saddr_bad = 0; ssel1 = 0; pause_bad = 0; aborting = 0; prev_sclk = 0;
        post_abort = 3'b111; rst_vals = '1; sin_cap = '0;
        @(negedge clk); start = 1'b1; addr = a;
        @(negedge clk); start = 1'b0; cyc = 1;
        while (cyc < 400) begin
            if (rst) rst = 1'b0;
            if (rd_valid) got_q.push_back(rd_data);
            if (sclk && !prev_sclk) begin
                if (npulse < W) sin_cap = {sin_cap[W-2:0], sin};
                npulse++;
            end
            prev_sclk = sclk;
            if (done) begin ndone++; done_cyc = cyc; end
            if (ssel && saddr !== a) saddr_bad = 1'b1;
            if (cyc == 1) ssel1 = ssel;
            if (aborting) begin post_abort = {ssel, sclk, busy}; abort = 1'b0; aborting = 0; end
            if (!busy && cyc > 1) break;
            start = 1'b0;
            if (cyc == bstart_cyc) begin start = 1'b1; addr = 3'd3; end
            if (rst_byte >= 0 && idx == rst_byte + 1 && sclk) begin
                rst = 1'b1; in_valid = 1'b0; #1;
                rst_vals = {sclk, sin, ssel, saddr, rd_data, rd_valid, done, busy, in_ready};
            end else begin
                if (abort_byte >= 0 && idx == abort_byte + 1 && sclk) begin
                    abort = 1'b1; aborting = 1;
                end
                want = 1'b1;
                if (idx == pause_at && pause_cnt < 10 && in_ready) begin
                    want = 1'b0; pause_cnt++;
                    if (sclk || !ssel) pause_bad = 1'b1;
                end
                in_valid = (idx < NB) ? want : 1'b0;
                in_data = tx[(idx < NB) ? idx : NB-1];
                if (in_ready && in_valid && !abort) idx++;
            end
            @(negedge clk); cyc++;
        end
        in_valid = 1'b0; start = 1'b0; abort = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (rd_valid) got_q.push_back(rd_data);
            if (done) ndone++;
        end
    endtask

    task automatic score(input string tag, input int nexp);
        chk({tag, "_rd_count"}, got_q.size(), nexp);
        while (got_q.size() > 0 && exp_q.size() > 0)
            chk({tag, "_rd_data"}, got_q.pop_front(), exp_q.pop_front());
        got_q.delete(); exp_q.delete();
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_sclk", sclk, 1'b0);
        chk("rst_sin", sin, 1'b0);
        chk("rst_ssel", ssel, 1'b0);
        chk("rst_saddr", saddr, 3'd0);
        chk("rst_rd_data", rd_data, 8'h00);
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // A: addr 5, bytes 0x01..0x0C, chain returns 0xA5 everywhere
        for (int n = 0; n < NB; n++) tx[n] = 8'(n + 1);
        preload({NB{8'hA5}});
        xfer(3'd5, -1, -1, -1, -1);
        chk("A_ssel_cyc1", ssel1, 1'b1);
        chk("A_saddr_stable", saddr_bad, 1'b0);
        chk("A_sclk_pulses", npulse, 96);
        chk("A_done_cyc", done_cyc, 1 + 12*17 + 1);
        chk("A_done_count", ndone, 1);
        chk("A_chain", chain, pack_tx());
        score("A", NB);

        // B: first byte 0x80 checks MSB-first sin; readback is run A's data
        tx[0] = 8'h80;
        for (int n = 1; n < NB; n++) tx[n] = 8'($urandom_range(0, 255));
        xfer(3'd1, -1, -1, -1, -1);
        chk("B_sin_0x80", sin_cap, 8'h80);
        chk("B_done_cyc", done_cyc, 206);
        chk("B_chain", chain, pack_tx());
        score("B", NB);

        // C: 10-cycle stall before byte 4
        for (int n = 0; n < NB; n++) tx[n] = 8'($urandom_range(0, 255));
        xfer(3'd6, 4, -1, -1, -1);
        chk("C_pause_cycles", pause_cnt, 10);
        chk("C_pause_idle", pause_bad, 1'b0);
        chk("C_done_cyc", done_cyc, 216);
        chk("C_chain", chain, pack_tx());
        score("C", NB);

        // D: start while busy is ignored
        xfer(3'd4, -1, -1, -1, 50);
        chk("D_saddr_stable", saddr_bad, 1'b0);
        chk("D_done_cyc", done_cyc, 206);
        chk("D_done_count", ndone, 1);
        score("D", NB);

        // E: abort in SHIFT_HI of byte 6
        xfer(3'd7, -1, 6, -1, -1);
        chk("E_post_abort", post_abort, 3'b000);
        chk("E_no_done", ndone, 0);
        score("E", 6);

        // F: reset during byte 2, then G: full transfer to addr 2
        xfer(3'd3, -1, -1, 2, -1);
        chk("F_rst_outputs", rst_vals, 18'd0);
        chk("F_no_done", ndone, 0);
        score("F", 2);
        for (int n = 0; n < NB; n++) tx[n] = 8'($urandom_range(0, 255));
        xfer(3'd2, -1, -1, -1, -1);
        chk("G_saddr_stable", saddr_bad, 1'b0);
        chk("G_done_cyc", done_cyc, 206);
        chk("G_done_count", ndone, 1);
        chk("G_chain", chain, pack_tx());
        score("G", NB);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
